// File: rtl/eth_rx_fcs_check_if.sv
// Purpose: MII receive nibble bus plus payload byte stream and per-frame status.
// Latency: n/a (signal bundle only).
// Backpressure: none; the MII side and the byte stream are strobe-only.
interface eth_rx_fcs_check_if;
  logic        rx_dv;
  logic        rx_er;
  logic [3:0]  rx_data;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_sof;
  logic        frame_done;
  logic        frame_good;
  logic [4:0]  frame_status;
  logic [15:0] byte_count;

  // Drives the MII nibbles and observes the payload and status.
  modport master (
    output rx_dv, rx_er, rx_data,
    input  out_valid, out_data, out_sof, frame_done, frame_good, frame_status, byte_count
  );

  // Receives the MII nibbles and produces the payload and status.
  modport slave (
    input  rx_dv, rx_er, rx_data,
    output out_valid, out_data, out_sof, frame_done, frame_good, frame_status, byte_count
  );
endinterface

// File: rtl/eth_rx_fcs_check.sv
// Purpose: MII receive path: preamble/SFD hunt, nibble-to-byte packing, CRC32 check, FCS strip.
// Latency: a payload byte leaves 4 bytes later, one cycle after the high nibble of the 5th-newer byte; status one cycle after rx_dv falls.
// Backpressure: none; bytes are strobed out and the downstream must accept every strobe.
module eth_rx_fcs_check #(
  parameter int MIN_FRAME = 64,
  parameter int MAX_FRAME = 1518,
  parameter int MIN_PRE   = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  eth_rx_fcs_check_if.slave bus
);

  localparam logic [31:0] POLY     = 32'h04C11DB7;
  localparam logic [31:0] RESIDUE  = 32'hC704DD7B;
  localparam logic [15:0] MIN_LEN  = 16'(MIN_FRAME);
  localparam logic [15:0] MAX_LEN  = 16'(MAX_FRAME);
  localparam logic [15:0] CNT_SAT  = 16'(MAX_FRAME + 1);
  localparam logic [7:0]  PRE_MIN  = 8'(MIN_PRE);

  typedef enum logic [1:0] {
    WAIT_IDLE,
    HUNT,
    DATA,
    DROP
  } state_t;

  state_t      state;
  logic [31:0] crc;
  logic [7:0]  pre_cnt;
  logic [15:0] byte_cnt;
  logic        phase;      // 1 when the low nibble of the current byte is held
  logic [3:0]  low_nib;
  logic [2:0]  fill;       // occupancy of the FCS holdback buffer, 0..4
  logic [7:0]  sbuf [4];   // sbuf[3] is the oldest byte
  logic        sof_pend;
  logic        err_rx;
  logic        err_long;

  logic [15:0] cnt_inc;
  logic [7:0]  asm_byte;
  logic [4:0]  st_next;
  logic [15:0] bc_next;

  // Four serial CRC steps, wire order: rx_data[0] is the first bit on the line.
  function automatic logic [31:0] crc_nibble(input logic [31:0] crc_in, input logic [3:0] d);
    logic [31:0] c;
    logic        fb;
    c = crc_in;
    for (int i = 0; i < 4; i++) begin
      fb = c[31] ^ d[i];
      c  = {c[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
    end
    return c;
  endfunction

  // Next byte count, the byte being assembled, and the status that would be reported now.
  always_comb begin
    cnt_inc  = (byte_cnt == CNT_SAT) ? byte_cnt : byte_cnt + 16'd1;
    asm_byte = {bus.rx_data, low_nib};
    st_next  = {err_rx | bus.rx_er, phase, err_long, (byte_cnt < MIN_LEN), (crc != RESIDUE)};
    bc_next  = (byte_cnt >= 16'd4) ? byte_cnt - 16'd4 : 16'd0;
  end

  // Receive FSM with datapath and registered outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state            <= WAIT_IDLE;
      crc              <= 32'hFFFFFFFF;
      pre_cnt          <= '0;
      byte_cnt         <= '0;
      phase            <= 1'b0;
      low_nib          <= '0;
      fill             <= '0;
      for (int i = 0; i < 4; i++) sbuf[i] <= '0;
      sof_pend         <= 1'b0;
      err_rx           <= 1'b0;
      err_long         <= 1'b0;
      bus.out_valid    <= 1'b0;
      bus.out_data     <= '0;
      bus.out_sof      <= 1'b0;
      bus.frame_done   <= 1'b0;
      bus.frame_good   <= 1'b0;
      bus.frame_status <= '0;
      bus.byte_count   <= '0;
    end else begin
      bus.out_valid  <= 1'b0;
      bus.out_sof    <= 1'b0;
      bus.frame_done <= 1'b0;
      case (state)
        // Never lock onto the tail of a frame that was in flight at reset.
        WAIT_IDLE: begin
          pre_cnt <= '0;
          if (!bus.rx_dv) state <= HUNT;
        end
        HUNT: begin
          if (!bus.rx_dv) begin
            pre_cnt <= '0;
          end else if (bus.rx_data == 4'h5) begin
            if (pre_cnt != 8'hFF) pre_cnt <= pre_cnt + 8'd1;
          end else if ((bus.rx_data == 4'hD) && (pre_cnt >= PRE_MIN)) begin
            state    <= DATA;
            crc      <= 32'hFFFFFFFF;
            byte_cnt <= '0;
            phase    <= 1'b0;
            fill     <= '0;
            sof_pend <= 1'b1;
            err_rx   <= 1'b0;
            err_long <= 1'b0;
          end else begin
            state <= DROP;
          end
        end
        DATA: begin
          if (bus.rx_dv) begin
            crc   <= crc_nibble(crc, bus.rx_data);
            phase <= ~phase;
            if (bus.rx_er) err_rx <= 1'b1;
            if (!phase) begin
              low_nib <= bus.rx_data;
            end else begin
              byte_cnt <= cnt_inc;
              if (cnt_inc > MAX_LEN) err_long <= 1'b1;
              sbuf[0] <= asm_byte;
              sbuf[1] <= sbuf[0];
              sbuf[2] <= sbuf[1];
              sbuf[3] <= sbuf[2];
              // Holdback full: the oldest byte cannot be FCS, release it.
              if (fill == 3'd4) begin
                if (cnt_inc <= MAX_LEN) begin
                  bus.out_valid <= 1'b1;
                  bus.out_data  <= sbuf[3];
                  bus.out_sof   <= sof_pend;
                  sof_pend      <= 1'b0;
                end
              end else begin
                fill <= fill + 3'd1;
              end
            end
          end else begin
            // End of frame: the held 4 bytes are the FCS and are dropped.
            state            <= HUNT;
            pre_cnt          <= '0;
            bus.frame_done   <= 1'b1;
            bus.frame_good   <= (st_next == 5'd0);
            bus.frame_status <= st_next;
            bus.byte_count   <= bc_next;
          end
        end
        DROP: begin
          pre_cnt <= '0;
          if (!bus.rx_dv) state <= HUNT;
        end
        default: state <= WAIT_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// Purpose: directed checks of the receive FCS checker against a reflected-CRC reference.
// Latency: n/a.
// Backpressure: n/a.
module tb_eth_rx_fcs_check;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  eth_rx_fcs_check_if bus ();

  eth_rx_fcs_check #(.MIN_FRAME(64), .MAX_FRAME(1518), .MIN_PRE(2)) dut (
    .Clk   (clk),
    .Reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  frm [$];
  logic [7:0]  exp_q [$];
  logic [7:0]  rx_q [$];
  logic        sof_q [$];
  int          done_cnt;
  int          good_cnt;
  logic [4:0]  last_st;
  logic        last_good;
  logic [15:0] last_bc;
  int          base_done;
  int          base_good;

  initial begin
    done_cnt = 0;
    good_cnt = 0;
  end

  // Collect emitted bytes and end-of-frame reports away from the active edge.
  always @(negedge clk) begin
    if (bus.out_valid) begin
      rx_q.push_back(bus.out_data);
      sof_q.push_back(bus.out_sof);
    end
    if (bus.frame_done) begin
      done_cnt  <= done_cnt + 1;
      good_cnt  <= good_cnt + (bus.frame_good ? 1 : 0);
      last_st   <= bus.frame_status;
      last_good <= bus.frame_good;
      last_bc   <= bus.byte_count;
    end
  end

  task automatic drive(input logic dv, input logic [3:0] d, input logic er);
    @(posedge clk);
    #1;
    bus.rx_dv   = dv;
    bus.rx_data = d;
    bus.rx_er   = er;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 4'h0, 1'b0);
  endtask

  task automatic clear_mon();
    rx_q.delete();
    sof_q.delete();
    exp_q.delete();
    base_done = done_cnt;
    base_good = good_cnt;
  endtask

  // Reference FCS: reflected CRC32, complemented, appended least significant byte first.
  task automatic append_fcs();
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < frm.size(); i++) begin
      c = c ^ {24'h0, frm[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    c = ~c;
    frm.push_back(c[7:0]);
    frm.push_back(c[15:8]);
    frm.push_back(c[23:16]);
    frm.push_back(c[31:24]);
  endtask

  task automatic build_frame(input int n, input logic [7:0] base);
    frm.delete();
    for (int i = 0; i < n; i++) begin
      frm.push_back(base + 8'(i));
      exp_q.push_back(base + 8'(i));
    end
    append_fcs();
  endtask

  task automatic send_frame(input int npre, input bit sfd, input int er_nib, input bit extra);
    for (int i = 0; i < npre; i++) drive(1'b1, 4'h5, 1'b0);
    if (sfd) drive(1'b1, 4'hD, 1'b0);
    for (int i = 0; i < frm.size(); i++) begin
      drive(1'b1, frm[i][3:0], (er_nib == 2 * i));
      drive(1'b1, frm[i][7:4], (er_nib == 2 * i + 1));
    end
    if (extra) drive(1'b1, 4'h0, 1'b0);
    drive(1'b0, 4'h0, 1'b0);
  endtask

  function automatic int data_mismatch(input int n);
    int m;
    m = 0;
    for (int i = 0; i < n; i++)
      if (i >= rx_q.size() || i >= exp_q.size() || rx_q[i] !== exp_q[i]) m++;
    return m;
  endfunction

  function automatic int sof_ones();
    int s;
    s = 0;
    for (int i = 0; i < sof_q.size(); i++) if (sof_q[i] === 1'b1) s++;
    return s;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    bus.rx_dv = 1'b0; bus.rx_er = 1'b0; bus.rx_data = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h expected 00", bus.out_data); end
    checks++; if (bus.out_sof !== 1'b0) begin errors++; $display("FAIL reset_out_sof: got %b expected 0", bus.out_sof); end
    checks++; if (bus.frame_done !== 1'b0 || bus.frame_good !== 1'b0) begin errors++; $display("FAIL reset_done_good: got %b%b expected 00", bus.frame_done, bus.frame_good); end
    checks++; if (bus.frame_status !== 5'd0 || bus.byte_count !== 16'd0) begin errors++; $display("FAIL reset_status: got %b/%0d expected 00000/0", bus.frame_status, bus.byte_count); end
    @(posedge clk); #1; reset = 1'b0;
    idle(2);
  endtask

  task automatic test_good();
    clear_mon(); build_frame(60, 8'h00); send_frame(15, 1, -1, 0); idle(3);
    checks++; if (rx_q.size() !== 60) begin errors++; $display("FAIL good_count: got %0d expected 60", rx_q.size()); end
    checks++; if (data_mismatch(60) !== 0) begin errors++; $display("FAIL good_data: got %0d mismatches expected 0", data_mismatch(60)); end
    checks++; if (sof_ones() !== 1 || sof_q.size() == 0 || sof_q[0] !== 1'b1) begin errors++; $display("FAIL good_sof: got %0d sof strobes expected 1 on first byte", sof_ones()); end
    checks++; if (done_cnt - base_done !== 1) begin errors++; $display("FAIL good_done: got %0d expected 1", done_cnt - base_done); end
    checks++; if (last_good !== 1'b1 || last_st !== 5'b00000) begin errors++; $display("FAIL good_status: got good=%b st=%b expected good=1 st=00000", last_good, last_st); end
    checks++; if (last_bc !== 16'd60) begin errors++; $display("FAIL good_bc: got %0d expected 60", last_bc); end
  endtask

  task automatic test_crc_err();
    clear_mon(); build_frame(60, 8'h00);
    frm[10] = frm[10] ^ 8'hF0; exp_q[10] = exp_q[10] ^ 8'hF0;
    send_frame(15, 1, -1, 0); idle(3);
    checks++; if (rx_q.size() !== 60 || data_mismatch(60) !== 0) begin errors++; $display("FAIL crc_data: got %0d bytes %0d mismatches expected 60/0", rx_q.size(), data_mismatch(60)); end
    checks++; if (done_cnt - base_done !== 1) begin errors++; $display("FAIL crc_done: got %0d expected 1", done_cnt - base_done); end
    checks++; if (last_good !== 1'b0 || last_st !== 5'b00001) begin errors++; $display("FAIL crc_status: got good=%b st=%b expected good=0 st=00001", last_good, last_st); end
  endtask

  task automatic test_runt();
    logic [7:0] s [9];
    s = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    clear_mon(); frm.delete();
    for (int i = 0; i < 9; i++) begin frm.push_back(s[i]); exp_q.push_back(s[i]); end
    frm.push_back(8'h26); frm.push_back(8'h39); frm.push_back(8'hF4); frm.push_back(8'hCB);
    send_frame(7, 1, -1, 0); idle(3);
    checks++; if (rx_q.size() !== 9 || data_mismatch(9) !== 0) begin errors++; $display("FAIL runt_data: got %0d bytes %0d mismatches expected 9/0", rx_q.size(), data_mismatch(9)); end
    checks++; if (done_cnt - base_done !== 1 || last_st !== 5'b00010) begin errors++; $display("FAIL runt_status: got done=%0d st=%b expected 1/00010", done_cnt - base_done, last_st); end
    checks++; if (last_bc !== 16'd9) begin errors++; $display("FAIL runt_bc: got %0d expected 9", last_bc); end
  endtask

  task automatic test_align_rxer();
    clear_mon(); build_frame(60, 8'h40); send_frame(15, 1, -1, 1); idle(3);
    checks++; if (rx_q.size() !== 60 || data_mismatch(60) !== 0) begin errors++; $display("FAIL align_data: got %0d bytes %0d mismatches expected 60/0", rx_q.size(), data_mismatch(60)); end
    checks++; if (done_cnt - base_done !== 1 || last_st[4:1] !== 4'b0100 || last_good !== 1'b0) begin errors++; $display("FAIL align_status: got done=%0d st=%b good=%b expected 1/0100x/0", done_cnt - base_done, last_st, last_good); end
    checks++; if (last_bc !== 16'd60) begin errors++; $display("FAIL align_bc: got %0d expected 60", last_bc); end
    clear_mon(); build_frame(60, 8'h10); send_frame(15, 1, 41, 0); idle(3);
    checks++; if (rx_q.size() !== 60 || data_mismatch(60) !== 0) begin errors++; $display("FAIL rxer_data: got %0d bytes %0d mismatches expected 60/0", rx_q.size(), data_mismatch(60)); end
    checks++; if (done_cnt - base_done !== 1 || last_st !== 5'b10000) begin errors++; $display("FAIL rxer_status: got done=%0d st=%b expected 1/10000", done_cnt - base_done, last_st); end
  endtask

  task automatic test_long();
    clear_mon(); build_frame(1596, 8'h00); send_frame(15, 1, -1, 0); idle(3);
    checks++; if (rx_q.size() !== 1514) begin errors++; $display("FAIL long_count: got %0d expected 1514", rx_q.size()); end
    checks++; if (data_mismatch(1514) !== 0) begin errors++; $display("FAIL long_data: got %0d mismatches expected 0", data_mismatch(1514)); end
    checks++; if (done_cnt - base_done !== 1 || last_st !== 5'b00100) begin errors++; $display("FAIL long_status: got done=%0d st=%b expected 1/00100", done_cnt - base_done, last_st); end
    checks++; if (last_bc !== 16'd1515) begin errors++; $display("FAIL long_bc: got %0d expected 1515", last_bc); end
  endtask

  task automatic test_preamble();
    clear_mon();
    for (int i = 0; i < 15; i++) drive(1'b1, 4'h5, 1'b0);
    idle(3);
    build_frame(60, 8'h00); send_frame(1, 1, -1, 0); idle(3);
    checks++; if (rx_q.size() !== 0 || done_cnt - base_done !== 0) begin errors++; $display("FAIL nosfd: got %0d bytes %0d done expected 0/0", rx_q.size(), done_cnt - base_done); end
    clear_mon(); build_frame(60, 8'h20); send_frame(2, 1, -1, 0); idle(3);
    checks++; if (rx_q.size() !== 60 || done_cnt - base_done !== 1 || last_st !== 5'b00000) begin errors++; $display("FAIL minpre: got %0d bytes %0d done st=%b expected 60/1/00000", rx_q.size(), done_cnt - base_done, last_st); end
  endtask

  task automatic test_reset_mid();
    build_frame(60, 8'h00);
    for (int i = 0; i < 15; i++) drive(1'b1, 4'h5, 1'b0);
    drive(1'b1, 4'hD, 1'b0);
    for (int i = 0; i < 20; i++) begin drive(1'b1, frm[i][3:0], 1'b0); drive(1'b1, frm[i][7:4], 1'b0); end
    @(posedge clk); #1; reset = 1'b1; bus.rx_dv = 1'b1; bus.rx_data = frm[20][3:0];
    @(posedge clk); #1; reset = 1'b0; bus.rx_data = frm[20][7:4];
    clear_mon();
    for (int i = 0; i < 29; i++) drive(1'b1, (i % 2 == 0) ? 4'h5 : 4'hD, 1'b0);
    idle(3);
    checks++; if (rx_q.size() !== 0 || done_cnt - base_done !== 0) begin errors++; $display("FAIL rstmid_quiet: got %0d bytes %0d done expected 0/0", rx_q.size(), done_cnt - base_done); end
    clear_mon(); build_frame(60, 8'h55); send_frame(15, 1, -1, 0); idle(3);
    checks++; if (rx_q.size() !== 60 || data_mismatch(60) !== 0 || sof_ones() !== 1) begin errors++; $display("FAIL rstmid_next: got %0d bytes %0d mismatches %0d sof expected 60/0/1", rx_q.size(), data_mismatch(60), sof_ones()); end
    checks++; if (done_cnt - base_done !== 1 || last_good !== 1'b1 || last_bc !== 16'd60) begin errors++; $display("FAIL rstmid_status: got done=%0d good=%b bc=%0d expected 1/1/60", done_cnt - base_done, last_good, last_bc); end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    build_frame(60, 8'h00); send_frame(15, 1, -1, 0);
    build_frame(61, 8'h80); send_frame(15, 1, -1, 0);
    idle(3);
    checks++; if (rx_q.size() !== 121 || data_mismatch(121) !== 0) begin errors++; $display("FAIL b2b_data: got %0d bytes %0d mismatches expected 121/0", rx_q.size(), data_mismatch(121)); end
    checks++; if (sof_ones() !== 2 || sof_q.size() < 61 || sof_q[0] !== 1'b1 || sof_q[60] !== 1'b1) begin errors++; $display("FAIL b2b_sof: got %0d sof strobes expected 2 at bytes 0 and 60", sof_ones()); end
    checks++; if (done_cnt - base_done !== 2 || good_cnt - base_good !== 2 || last_bc !== 16'd61) begin errors++; $display("FAIL b2b_status: got done=%0d good=%0d bc=%0d expected 2/2/61", done_cnt - base_done, good_cnt - base_good, last_bc); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_good();
    test_crc_err();
    test_runt();
    test_align_rxer();
    test_long();
    test_preamble();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
